// File: rtl/bus_bridge_slave_pkg.sv
// Shared definitions for the bus bridge slave: frame widths, FSM encoding and
// the byte returned when the remote never answers a read.
package bus_bridge_slave_pkg;

    localparam int BB_DATA_WIDTH     = 8;
    localparam int BB_ADDR_WIDTH_DEF = 12;
    localparam int UART_TX_WIDTH     = BB_DATA_WIDTH + BB_ADDR_WIDTH_DEF + 1;
    localparam int UART_RX_WIDTH     = BB_DATA_WIDTH;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_SEND,
        ST_TXWAIT,
        ST_RWAIT,
        ST_GRANT,
        ST_RDATA
    } bbs_state_t;

endpackage

// File: rtl/bus_bridge_slave_uart.sv
// Fixed-width UART: start bit, TX_WIDTH/RX_WIDTH data bits LSB first, stop bit.
// ready rises after each received byte and falls at the next start bit.
module bus_bridge_slave_uart #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int TX_WIDTH         = 21,
    parameter int RX_WIDTH         = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [TX_WIDTH-1:0] data_tx,
    input  logic                data_en,
    output logic                tx_busy,
    output logic                u_tx,
    input  logic                u_rx,
    output logic [RX_WIDTH-1:0] data_rx,
    output logic                ready
);
    localparam int TMR_W = $clog2(2 * CLOCKS_PER_PULSE);
    localparam int TXB_W = $clog2(TX_WIDTH + 2);
    localparam int RXB_W = $clog2(RX_WIDTH + 1);
    localparam logic [TMR_W-1:0] BIT_LAST     = TMR_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [TMR_W-1:0] FIRST_SAMPLE = TMR_W'(CLOCKS_PER_PULSE + CLOCKS_PER_PULSE / 2 - 1);

    logic [TX_WIDTH:0]   tx_sh;
    logic [TMR_W-1:0]    tx_tmr;
    logic [TXB_W-1:0]    tx_bits;
    logic                rx_s1, rx_s2, rx_act;
    logic [TMR_W-1:0]    rx_tmr;
    logic [RXB_W-1:0]    rx_bits;
    logic [RX_WIDTH-1:0] rx_sh;

    assign data_rx = rx_sh;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_busy <= 1'b0;
            u_tx    <= 1'b1;
            tx_sh   <= '0;
            tx_tmr  <= '0;
            tx_bits <= '0;
        end else if (!tx_busy) begin
            if (data_en) begin
                tx_busy <= 1'b1;
                u_tx    <= 1'b0;
                tx_sh   <= {1'b1, data_tx};
                tx_tmr  <= BIT_LAST;
                tx_bits <= TXB_W'(TX_WIDTH + 1);
            end
        end else if (tx_tmr == '0) begin
            // Stop bit has already been on the line for a full period when bits hit zero.
            if (tx_bits == '0) begin
                tx_busy <= 1'b0;
            end else begin
                u_tx    <= tx_sh[0];
                tx_sh   <= {1'b0, tx_sh[TX_WIDTH:1]};
                tx_bits <= tx_bits - 1'b1;
                tx_tmr  <= BIT_LAST;
            end
        end else begin
            tx_tmr <= tx_tmr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_act  <= 1'b0;
            rx_tmr  <= '0;
            rx_bits <= '0;
            rx_sh   <= '0;
            ready   <= 1'b0;
        end else begin
            rx_s1 <= u_rx;
            rx_s2 <= rx_s1;
            if (!rx_act) begin
                if (!rx_s2) begin
                    rx_act  <= 1'b1;
                    ready   <= 1'b0;
                    rx_tmr  <= FIRST_SAMPLE;
                    rx_bits <= RXB_W'(RX_WIDTH);
                end
            end else if (rx_tmr == '0) begin
                if (rx_bits == '0) begin
                    rx_act <= 1'b0;
                    ready  <= 1'b1;
                end else begin
                    rx_sh   <= {rx_s2, rx_sh[RX_WIDTH-1:1]};
                    rx_bits <= rx_bits - 1'b1;
                    rx_tmr  <= BIT_LAST;
                end
            end else begin
                rx_tmr <= rx_tmr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_bridge_slave.sv
// Bus slave that forwards serial bus transactions over UART as {mode, data, addr}
// frames; reads are split and answered once the remote reply (or timeout) arrives.
//
// state  | meaning
// IDLE   | ready for a transaction, sready=1
// ADDR   | shifting address bits
// WDATA  | shifting write data bits
// SEND   | one-cycle UART load
// TXWAIT | UART frame in flight
// RWAIT  | split, waiting for reply or timeout
// GRANT  | split, waiting for split_grant
// RDATA  | shifting read byte out on srdata
module bus_bridge_slave
    import bus_bridge_slave_pkg::*;
#(
    parameter int DATA_WIDTH            = BB_DATA_WIDTH,
    parameter int BB_ADDR_WIDTH         = BB_ADDR_WIDTH_DEF,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int RESP_TIMEOUT          = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic ssplit,
    input  logic split_grant,
    output logic u_tx,
    input  logic u_rx
);
    localparam int TX_W    = DATA_WIDTH + BB_ADDR_WIDTH + 1;
    localparam int CNT_MAX = (BB_ADDR_WIDTH > DATA_WIDTH) ? BB_ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(BB_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);

    bbs_state_t               state, state_d;
    logic                     mode_r;
    logic [BB_ADDR_WIDTH-1:0] addr_sh;
    logic [DATA_WIDTH-1:0]    data_sh;
    logic [DATA_WIDTH-1:0]    rd_sh;
    logic [CNT_W-1:0]         bit_cnt;
    logic [TMO_W-1:0]         tmo_cnt;
    logic                     busy_seen;
    logic                     rdy_q;
    logic                     data_en;
    logic                     tx_busy;
    logic                     u_ready;
    logic [DATA_WIDTH-1:0]    u_rx_data;
    logic [TX_W-1:0]          frame;
    logic                     rx_edge;

    assign frame   = {mode_r, (mode_r ? data_sh : {DATA_WIDTH{1'b0}}), addr_sh};
    assign rx_edge = u_ready & ~rdy_q;

    assign sready = (state == ST_IDLE);
    assign ssplit = (state == ST_RWAIT) || (state == ST_GRANT);
    assign svalid = (state == ST_RDATA);
    assign srdata = svalid & rd_sh[0];

    bus_bridge_slave_uart #(
        .CLOCKS_PER_PULSE (UART_CLOCKS_PER_PULSE),
        .TX_WIDTH         (TX_W),
        .RX_WIDTH         (DATA_WIDTH)
    ) u_uart (
        .clk     (clk),
        .rstn    (rstn),
        .data_tx (frame),
        .data_en (data_en),
        .tx_busy (tx_busy),
        .u_tx    (u_tx),
        .u_rx    (u_rx),
        .data_rx (u_rx_data),
        .ready   (u_ready)
    );

    always_comb begin
        state_d = state;
        data_en = 1'b0;
        case (state)
            ST_IDLE:   if (mvalid) state_d = ST_ADDR;
            ST_ADDR:   if (mvalid && bit_cnt == ADDR_LAST) state_d = mode_r ? ST_WDATA : ST_SEND;
            ST_WDATA:  if (mvalid && bit_cnt == DATA_LAST) state_d = ST_SEND;
            ST_SEND: begin
                data_en = 1'b1;
                state_d = ST_TXWAIT;
            end
            ST_TXWAIT: if (busy_seen && !tx_busy) state_d = mode_r ? ST_IDLE : ST_RWAIT;
            ST_RWAIT:  if (rx_edge || tmo_cnt == TMO_LAST) state_d = ST_GRANT;
            ST_GRANT:  if (split_grant) state_d = ST_RDATA;
            ST_RDATA:  if (bit_cnt == DATA_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            mode_r    <= 1'b0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rd_sh     <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            busy_seen <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state <= state_d;
            rdy_q <= u_ready;
            case (state)
                ST_IDLE: if (mvalid) begin
                    mode_r  <= smode;
                    addr_sh <= {swdata, addr_sh[BB_ADDR_WIDTH-1:1]};
                    bit_cnt <= CNT_W'(1);
                end
                ST_ADDR: if (mvalid) begin
                    addr_sh <= {swdata, addr_sh[BB_ADDR_WIDTH-1:1]};
                    bit_cnt <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + 1'b1;
                end
                ST_WDATA: if (mvalid) begin
                    data_sh <= {swdata, data_sh[DATA_WIDTH-1:1]};
                    bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                end
                ST_SEND: busy_seen <= 1'b0;
                ST_TXWAIT: begin
                    if (tx_busy) busy_seen <= 1'b1;
                    tmo_cnt <= '0;
                end
                // A reply on the timeout cycle takes priority over the fill byte.
                ST_RWAIT: begin
                    if (rx_edge) rd_sh <= u_rx_data;
                    else if (tmo_cnt == TMO_LAST) rd_sh <= DATA_WIDTH'(TIMEOUT_FILL);
                    if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
                end
                ST_RDATA: begin
                    rd_sh   <= {1'b0, rd_sh[DATA_WIDTH-1:1]};
                    bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_slave.sv
// Bench for bus_bridge_slave: drives serial bus transactions, decodes UART frames,
// plays the remote side and compares against frames/replies computed here.
module tb_bus_bridge_slave;
    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int CPP = 4;
    localparam int TMO = 100;
    localparam int FW  = DW + AW + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic swdata = 1'b0;
    logic smode = 1'b0;
    logic mvalid = 1'b0;
    logic split_grant = 1'b0;
    logic u_rx = 1'b1;
    logic srdata, svalid, sready, ssplit, u_tx;

    int tests_run = 0;
    int tests_failed = 0;
    logic [FW-1:0] mon_q[$];
    bit ssplit_seen = 1'b0;

    always #5 clk = ~clk;

    bus_bridge_slave #(
        .DATA_WIDTH            (DW),
        .BB_ADDR_WIDTH         (AW),
        .UART_CLOCKS_PER_PULSE (CPP),
        .RESP_TIMEOUT          (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .swdata      (swdata),
        .smode       (smode),
        .mvalid      (mvalid),
        .srdata      (srdata),
        .svalid      (svalid),
        .sready      (sready),
        .ssplit      (ssplit),
        .split_grant (split_grant),
        .u_tx        (u_tx),
        .u_rx        (u_rx)
    );

    always @(negedge clk) if (ssplit) ssplit_seen <= 1'b1;

    // UART frame decoder on u_tx
    initial forever begin
        logic [FW-1:0] f;
        f = '0;
        @(negedge u_tx);
        repeat (CPP / 2) @(negedge clk);
        for (int i = 0; i < FW; i++) begin
            repeat (CPP) @(negedge clk);
            f[i] = u_tx;
        end
        repeat (CPP) @(negedge clk);
        mon_q.push_back(f);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1);
    end

    task automatic uart_send(input logic [7:0] b);
        u_rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        u_rx = 1'b1;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_bit(input logic m, input logic b, input int gap);
        smode = m;
        swdata = b;
        mvalid = 1'b1;
        @(negedge clk);
        mvalid = 1'b0;
        swdata = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        tests_run++; if (srdata !== 1'b0) begin tests_failed++; $display("FAIL reset_srdata got %b want 0", srdata); end
        tests_run++; if (svalid !== 1'b0) begin tests_failed++; $display("FAIL reset_svalid got %b want 0", svalid); end
        tests_run++; if (sready !== 1'b1) begin tests_failed++; $display("FAIL reset_sready got %b want 1", sready); end
        tests_run++; if (ssplit !== 1'b0) begin tests_failed++; $display("FAIL reset_ssplit got %b want 0", ssplit); end
        tests_run++; if (u_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_u_tx got %b want 1", u_tx); end
    endtask

    task automatic test_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int gap);
        logic [FW-1:0] exp_frame, got;
        int n;
        exp_frame = FW'((1 << (DW + AW)) | (int'(data) << AW) | int'(addr));
        mon_q.delete();
        ssplit_seen = 1'b0;
        send_bit(1'b1, addr[0], gap);
        tests_run++; if (sready !== 1'b0) begin tests_failed++; $display("FAIL write_sready_drop got %b want 0", sready); end
        for (int i = 1; i < AW; i++) send_bit(1'b1, addr[i], gap);
        for (int i = 0; i < DW; i++) send_bit(1'b1, data[i], gap);
        n = 0;
        while (sready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        tests_run++; if (n >= 1000) begin tests_failed++; $display("FAIL write_done_timeout waited %0d cycles, limit 1000", n); end
        repeat (5) @(negedge clk);
        got = (mon_q.size() > 0) ? mon_q[0] : 'x;
        tests_run++; if (mon_q.size() !== 1) begin tests_failed++; $display("FAIL write_frame_count got %0d want 1", mon_q.size()); end
        tests_run++; if (got !== exp_frame) begin tests_failed++; $display("FAIL write_frame got %h want %h", got, exp_frame); end
        tests_run++; if (ssplit_seen !== 1'b0) begin tests_failed++; $display("FAIL write_no_split got %b want 0", ssplit_seen); end
    endtask

    task automatic test_read(input logic [AW-1:0] addr, input logic [7:0] reply, input bit do_reply, input int gap);
        logic [FW-1:0] exp_frame, got;
        logic [DW-1:0] exp_data, rd;
        int n, vcnt;
        logic split_first;
        exp_frame = FW'(int'(addr));
        exp_data = do_reply ? reply : 8'hFF;
        mon_q.delete();
        for (int i = 0; i < AW; i++) send_bit(1'b0, addr[i], gap);
        n = 0;
        while (ssplit !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        tests_run++; if (n >= 1000) begin tests_failed++; $display("FAIL read_split_timeout waited %0d cycles, limit 1000", n); end
        got = (mon_q.size() > 0) ? mon_q[0] : 'x;
        tests_run++; if (got !== exp_frame) begin tests_failed++; $display("FAIL read_frame got %h want %h", got, exp_frame); end
        if (do_reply) begin
            uart_send(reply);
            repeat (10) @(negedge clk);
            tests_run++; if (ssplit !== 1'b1 || svalid !== 1'b0) begin tests_failed++; $display("FAIL read_hold_split got ssplit=%b svalid=%b want 1/0", ssplit, svalid); end
            split_grant = 1'b1;
            @(negedge clk);
        end else begin
            split_grant = 1'b1;
            n = 0;
            while (svalid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            tests_run++; if (n !== TMO + 1) begin tests_failed++; $display("FAIL read_timeout_latency got %0d want %0d", n, TMO + 1); end
        end
        split_first = ssplit;
        vcnt = 0;
        rd = '0;
        for (int i = 0; i < DW; i++) begin
            rd[i] = srdata;
            vcnt += (svalid === 1'b1) ? 1 : 0;
            @(negedge clk);
        end
        split_grant = 1'b0;
        tests_run++; if (split_first !== 1'b0) begin tests_failed++; $display("FAIL read_split_release got %b want 0", split_first); end
        tests_run++; if (vcnt !== DW) begin tests_failed++; $display("FAIL read_svalid_count got %0d want %0d", vcnt, DW); end
        tests_run++; if (rd !== exp_data) begin tests_failed++; $display("FAIL read_data got %h want %h", rd, exp_data); end
        tests_run++; if (svalid !== 1'b0 || sready !== 1'b1) begin tests_failed++; $display("FAIL read_end got svalid=%b sready=%b want 0/1", svalid, sready); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        d = 8'h5C;
        mon_q.delete();
        for (int i = 0; i < AW; i++) send_bit(1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, d[i], 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        tests_run++; if (mon_q.size() !== 0) begin tests_failed++; $display("FAIL reset_mid_no_frame got %0d frames want 0", mon_q.size()); end
        test_write(12'h001, 8'h01, 0);
    endtask

    task automatic test_stray();
        uart_send(8'h5A);
        repeat (10) @(negedge clk);
        tests_run++; if (sready !== 1'b1 || ssplit !== 1'b0) begin tests_failed++; $display("FAIL stray_idle got sready=%b ssplit=%b want 1/0", sready, ssplit); end
        test_read(12'h002, 8'h77, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            test_write(AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
        for (int k = 0; k < 3; k++)
            test_read(AW'($urandom), 8'($urandom), 1'b1, int'($urandom_range(0, 2)));
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        @(negedge clk);
        test_write(12'h123, 8'hA5, 0);
        test_read(12'h0F0, 8'h3C, 1'b1, 0);
        test_read(12'h2B7, 8'h00, 1'b0, 0);
        test_write(12'h123, 8'hA5, 3);
        test_reset_mid();
        test_stray();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_bridge_slave.md
# bus_bridge_slave

Remote-side counterpart of the bus bridge master: responds as a slave on the local serial bus and forwards each bus transaction over UART to the remote system as a {mode, data, addr} frame. Write transactions are posted. A read issues a UART request, releases the bus with a split, and waits for the one-byte UART reply. When the bus grants the split back, the reply byte is shifted back to the master.

## Interface
Parameters:
- DATA_WIDTH, 8, bus and UART data width
- BB_ADDR_WIDTH, 12, serial address bits received from the bus and forwarded in the UART frame
- UART_CLOCKS_PER_PULSE, 5208, UART bit period in clk cycles
- RESP_TIMEOUT, 1000000, clk cycles allowed for a UART read reply

Ports:
- clk  in  1  system clock; one clock domain, all logic on its rising edge
- rstn  in  1  reset, synchronous, active-low
- swdata  in  1  serial address/write data from master, LSB first
- smode  in  1  0 read, 1 write; sampled with the first address bit
- mvalid  in  1  swdata bit valid
- srdata  out  1  serial read data, LSB first
- svalid  out  1  srdata bit valid
- sready  out  1  slave idle, can accept a transaction
- ssplit  out  1  split request: read reply pending, bus may be released
- split_grant  in  1  bus returned to this slave for the split reply
- u_tx  out  1  UART transmit to remote
- u_rx  in  1  UART receive from remote

## Operation
- UART TX frame is DATA_WIDTH+BB_ADDR_WIDTH+1 bits: {mode, data, addr}. Read frames carry data=0.
- UART RX frame is DATA_WIDTH bits of read data.
- States:
  - IDLE: sready=1. On mvalid, capture bit 0 of the address, latch smode, go to ADDR.
  - ADDR: shift one address bit per mvalid cycle. Gaps with mvalid=0 hold the state. After BB_ADDR_WIDTH bits, go to WDATA if write, else SEND.
  - WDATA: shift DATA_WIDTH bits, then go to SEND.
  - SEND: pulse the uart data_en for 1 cycle with the frame. Go to TXWAIT.
  - TXWAIT: wait for tx_busy high then low. A write then goes to IDLE; a read goes to RWAIT.
  - RWAIT: ssplit=1, timeout counter runs. A rising edge of the uart ready loads the rx byte into the read register. The counter reaching RESP_TIMEOUT loads 8'hFF. Either event goes to GRANT.
  - GRANT: ssplit=1 until split_grant is sampled high, then go to RDATA. ssplit deasserts in the first RDATA cycle.
  - RDATA: drive srdata with svalid=1 for DATA_WIDTH consecutive cycles, LSB first, then go to IDLE.
- mvalid outside IDLE/ADDR/WDATA is ignored.
- UART ready edges outside RWAIT are discarded; no buffering.
- Bit counter width is clog2 of max(BB_ADDR_WIDTH, DATA_WIDTH)+1. The timeout counter saturates and clears on entry to RWAIT.

## Timing
- Reset values: srdata=0, svalid=0, sready=1, ssplit=0, u_tx=1 (idle line). FSM in IDLE, all registers 0.
- Reset mid-operation abandons the transaction. The UART is reset too, so u_tx returns to 1 on the next cycle; no partial frame is retransmitted.
- sready drops the cycle after the first mvalid bit and stays low until return to IDLE.
- Read data is driven the cycle after split_grant is sampled.
- If the last address bit and the split request coincide with reset, reset wins.
- A UART reply arriving on the same cycle as the timeout: the reply wins.

## Structure
- Shared package holds:
  - the frame width localparams (UART TX width = DATA_WIDTH+BB_ADDR_WIDTH+1, RX width = DATA_WIDTH)
  - the FSM state encoding
  - the timeout fill value 8'hFF
- One sub-module: the existing uart, configured with TX width 21 and RX width 8 at defaults. Its reset is tied to rstn.
- The FSM, shift registers and counters live in bus_bridge_slave itself.

## Test plan
- Write addr 0x123, data 0xA5 (all bits, mvalid contiguous) -> one UART frame 0x1A5123; sready high again after TX completes; ssplit never asserted.
- Read addr 0x0F0; remote replies 0x3C -> UART frame 0x00F0; ssplit high until split_grant; srdata shows 0,0,1,1,1,1,0,0 on 8 consecutive svalid cycles.
- Read with no reply and RESP_TIMEOUT=100 -> 8'hFF returned after split_grant, 100 cycles after RWAIT entry.
- Write address sent with mvalid gaps of 3 cycles between bits -> identical frame to the contiguous case.
- Reset asserted mid-WDATA, then a fresh write addr 0x001, data 0x01 -> only frame 0x101001 observed; outputs at reset values during reset.
- Unsolicited UART byte while IDLE, then read addr 0x002 with reply 0x77 -> 0x77 returned; the stray byte is discarded.
